vga_scan_scaler: RTL and testbench
==================================

# vga_scan_scaler

- Upstream scan stage of the video path. Generates the display timing and the registered pixel coordinates consumed by the palettized sprite stages.
- Also produces a sprite ROM address pre-scaled from the screen raster to a smaller source image. The address is computed with incremental accumulators (no multipliers or dividers), so downstream ROM reads stay on the pixel clock.
- Default timing is 640x480@60 with an 800x525 total raster.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
- SRC_W, 320, source image width (1..H_ACTIVE)
- SRC_H, 240, source image height (1..V_ACTIVE)
- ADDR_W, 17, rom_address width (≥ ceil(log2(SRC_W*SRC_H)))

Ports:
- vga_clk  in  1  pixel clock, the only clock
- reset  in  1  synchronous, active-high
- DrawX  out  10  current pixel column, 0..H_TOTAL-1
- DrawY  out  10  current line, 0..V_TOTAL-1
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- blank  out  1  high = visible pixel (colour may be driven)
- frame_start  out  1  one-cycle pulse at (0,0)
- line_start  out  1  one-cycle pulse at DrawX=0, every line
- rom_address  out  ADDR_W  floor(DrawY*SRC_H/V_ACTIVE)*SRC_W + floor(DrawX*SRC_W/H_ACTIVE) when blank=1; 0 otherwise

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- hc counts 0..H_TOTAL-1 and wraps. vc increments when hc wraps and itself wraps after V_TOTAL-1.
- All outputs are registered and mutually aligned: every output describes the same (hc,vc) in the same cycle.
- Decodes:
  - blank = hc<H_ACTIVE && vc<V_ACTIVE.
  - hs = 0 iff H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC, independent of vc.
  - vs = 0 iff V_ACTIVE+V_FP ≤ vc < V_ACTIVE+V_FP+V_SYNC, for the whole line.
  - line_start = (hc==0); frame_start = (hc==0 && vc==0).
- X scaler (registers x_acc, x_src):
  - Both cleared when hc wraps to 0.
  - On each step hc→hc+1 with hc+1<H_ACTIVE: x_acc += SRC_W. If the result is ≥ H_ACTIVE, subtract H_ACTIVE and x_src += 1.
  - Held during horizontal blanking.
  - Invariant: x_src = floor(hc*SRC_W/H_ACTIVE).
- Y scaler (registers y_acc, row_base):
  - Cleared when vc wraps to 0.
  - On each step vc→vc+1 with vc+1<V_ACTIVE: y_acc += SRC_H. If the result is ≥ V_ACTIVE, subtract V_ACTIVE and row_base += SRC_W.
  - Held in vertical blanking.
  - Invariant: row_base = floor(vc*SRC_H/V_ACTIVE)*SRC_W.
- rom_address = blank ? row_base + x_src : 0.
- Widths:
  - Accumulators are wide enough for H_ACTIVE+SRC_W-1 (respectively V_ACTIVE+SRC_H-1).
  - At most one increment occurs per step because SRC ≤ ACTIVE.
  - No truncation in the address sum.

## Timing
- Reset values, held while reset=1:
  - DrawX=H_TOTAL-1, DrawY=V_TOTAL-1 (hc, vc preset to the last raster position)
  - hs=1, vs=1, blank=0
  - frame_start=0, line_start=0, rom_address=0
  - all accumulators 0
- First cycle after reset deasserts: DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1, rom_address=0.
- Latency: zero between coordinates and the decoded outputs. Downstream ROM is read on the opposite clock edge using these outputs.
- Reset asserted mid-frame: takes effect on the next edge, aborts the frame, and restarts as above. No partial sync pulse is stretched; hs/vs return to 1 immediately.
- Wrap-around at (H_TOTAL-1, V_TOTAL-1) → (0,0) on the next cycle, with frame_start=1.
- Sync pulses begin and end exactly on the counter boundaries above; no glitch cycles.

## Test plan
- Reset held 5 cycles, then released → cycle 1: DrawX=0, DrawY=0, blank=1, frame_start=1, rom_address=0. Next frame_start exactly 420000 cycles later.
- One line observed → hs low for exactly 96 cycles, DrawX 656..751. blank low for DrawX 640..799. line_start period 800.
- One frame observed → vs low on DrawY 490..491 only (1600 cycles). blank=0 for all DrawY ≥ 480.
- Address checks with defaults:
  - (2,0) → 1
  - (2,2) → 321
  - (639,479) → 76799
  - (640,10) → 0 with blank=0
  - Compare against floor-formula model for every visible pixel.
- Reset asserted at (300,200) for 3 cycles → reset values during reset. After release, (0,0) with frame_start=1 and addresses match the model for the full following frame.
- SRC_W=640, SRC_H=480 → rom_address = DrawY*640+DrawX for every visible pixel, e.g. (639,479) → 307199.

Source files
------------

// File: rtl/vga_scan_scaler.sv
// VGA raster generator with registered sync/blank decodes and a sprite ROM
// address scaled from the screen raster to a smaller source image.
module vga_scan_scaler #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SRC_W    = 320,
    parameter int SRC_H    = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              vga_clk,
    input  logic              reset,
    output logic [9:0]        DrawX,
    output logic [9:0]        DrawY,
    output logic              hs,
    output logic              vs,
    output logic              blank,
    output logic              frame_start,
    output logic              line_start,
    output logic [ADDR_W-1:0] rom_address
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Accumulators hold up to ACTIVE+SRC-1 before the conditional subtract.
    localparam int XA_W = $clog2(H_ACTIVE + SRC_W);
    localparam int YA_W = $clog2(V_ACTIVE + SRC_H);
    localparam int XS_W = $clog2(SRC_W + 1);

    localparam logic [XA_W-1:0]   X_STEP   = XA_W'(SRC_W);
    localparam logic [XA_W-1:0]   X_MOD    = XA_W'(H_ACTIVE);
    localparam logic [YA_W-1:0]   Y_STEP   = YA_W'(SRC_H);
    localparam logic [YA_W-1:0]   Y_MOD    = YA_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

    logic [9:0]        hc_q, hc_d;
    logic [9:0]        vc_q, vc_d;
    logic [XA_W-1:0]   x_acc_q, x_acc_d, x_sum;
    logic [XS_W-1:0]   x_src_q, x_src_d;
    logic [YA_W-1:0]   y_acc_q, y_acc_d, y_sum;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              blank_q, blank_d;
    logic              fs_q, fs_d;
    logic              ls_q, ls_d;
    logic [ADDR_W-1:0] rom_q, rom_d;
    logic              h_wrap;

    // Raster counters
    always_comb begin
        h_wrap = (hc_q == H_LAST);
        hc_d   = hc_q + 10'd1;
        vc_d   = vc_q;
        if (h_wrap) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
        end
    end

    // Horizontal scaler: steps only on visible columns, cleared at line start.
    always_comb begin
        x_acc_d = x_acc_q;
        x_src_d = x_src_q;
        x_sum   = x_acc_q + X_STEP;
        if (h_wrap) begin
            x_acc_d = '0;
            x_src_d = '0;
        end else if (hc_d < H_ACT) begin
            if (x_sum >= X_MOD) begin
                x_acc_d = x_sum - X_MOD;
                x_src_d = x_src_q + 1'b1;
            end else begin
                x_acc_d = x_sum;
            end
        end
    end

    // Vertical scaler: advances once per line, row_base carries the SRC_W stride.
    always_comb begin
        y_acc_d    = y_acc_q;
        row_base_d = row_base_q;
        y_sum      = y_acc_q + Y_STEP;
        if (h_wrap) begin
            if (vc_d == '0) begin
                y_acc_d    = '0;
                row_base_d = '0;
            end else if (vc_d < V_ACT) begin
                if (y_sum >= Y_MOD) begin
                    y_acc_d    = y_sum - Y_MOD;
                    row_base_d = row_base_q + ROW_STEP;
                end else begin
                    y_acc_d = y_sum;
                end
            end
        end
    end

    // Decodes use next-state coordinates so registered outputs align with DrawX/DrawY.
    always_comb begin
        blank_d = (hc_d < H_ACT) && (vc_d < V_ACT);
        hs_d    = !((hc_d >= HS_BEG) && (hc_d < HS_END));
        vs_d    = !((vc_d >= VS_BEG) && (vc_d < VS_END));
        ls_d    = (hc_d == '0);
        fs_d    = (hc_d == '0) && (vc_d == '0);
        rom_d   = blank_d ? (row_base_d + ADDR_W'(x_src_d)) : '0;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc_q       <= H_LAST;
            vc_q       <= V_LAST;
            x_acc_q    <= '0;
            x_src_q    <= '0;
            y_acc_q    <= '0;
            row_base_q <= '0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            blank_q    <= 1'b0;
            fs_q       <= 1'b0;
            ls_q       <= 1'b0;
            rom_q      <= '0;
        end else begin
            hc_q       <= hc_d;
            vc_q       <= vc_d;
            x_acc_q    <= x_acc_d;
            x_src_q    <= x_src_d;
            y_acc_q    <= y_acc_d;
            row_base_q <= row_base_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            blank_q    <= blank_d;
            fs_q       <= fs_d;
            ls_q       <= ls_d;
            rom_q      <= rom_d;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign rom_address = rom_q;

endmodule

// File: tb/tb_vga_scan_scaler.sv
// Checks three scaler configurations against a floor-formula raster model,
// including initial reset, a mid-frame reset and hand-computed address points.
module tb_vga_scan_scaler;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        fs;
        logic        ls;
        logic [31:0] rom;
    } exp_t;

    // Small raster shared by A (10x5 source) and B (identity source).
    localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 3;
    localparam int SVA = 12, SVF = 1, SVS = 2, SVB = 2;
    localparam int FA  = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);
    localparam int FC  = 800 * 525;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [9:0] xa, ya, xb, yb, xc, yc;
    logic hsa, vsa, bla, fsa, lsa, hsb, vsb, blb, fsb, lsb, hsc, vsc, blc, fsc, lsc;
    logic [5:0]  roma;
    logic [7:0]  romb;
    logic [16:0] romc;

    vga_scan_scaler #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .SRC_W(10), .SRC_H(5), .ADDR_W(6)) dut_a (
        .vga_clk(clk), .reset(rst), .DrawX(xa), .DrawY(ya), .hs(hsa), .vs(vsa),
        .blank(bla), .frame_start(fsa), .line_start(lsa), .rom_address(roma));

    vga_scan_scaler #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .SRC_W(SHA), .SRC_H(SVA), .ADDR_W(8)) dut_b (
        .vga_clk(clk), .reset(rst), .DrawX(xb), .DrawY(yb), .hs(hsb), .vs(vsb),
        .blank(blb), .frame_start(fsb), .line_start(lsb), .rom_address(romb));

    vga_scan_scaler dut_c (
        .vga_clk(clk), .reset(rst), .DrawX(xc), .DrawY(yc), .hs(hsc), .vs(vsc),
        .blank(blc), .frame_start(fsc), .line_start(lsc), .rom_address(romc));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model state: frame position of each DUT, advanced on the clock.
    bit started = 1'b0;
    bit in_rst  = 1'b1;
    int pa = 0, pb = 0, pc = 0;

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            in_rst <= 1'b1;
            pa <= FA - 1;
            pb <= FA - 1;
            pc <= FC - 1;
        end else begin
            in_rst <= 1'b0;
            pa <= (pa + 1) % FA;
            pb <= (pb + 1) % FA;
            pc <= (pc + 1) % FC;
        end
    end

    function automatic exp_t model(bit r, int pos, int ha, int hf, int hsy, int hb,
                                   int va, int vf, int vsy, int vb, int sw, int sh);
        exp_t e;
        int ht = ha + hf + hsy + hb;
        int vt = va + vf + vsy + vb;
        int x  = pos % ht;
        int y  = pos / ht;
        if (r) begin
            e.x = 10'(ht - 1);
            e.y = 10'(vt - 1);
            e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0;
            e.fs = 1'b0; e.ls = 1'b0; e.rom = 32'd0;
        end else begin
            e.x     = 10'(x);
            e.y     = 10'(y);
            e.hs    = !(x >= ha + hf && x < ha + hf + hsy);
            e.vs    = !(y >= va + vf && y < va + vf + vsy);
            e.blank = (x < ha) && (y < va);
            e.ls    = (x == 0);
            e.fs    = (x == 0) && (y == 0);
            e.rom   = e.blank ? 32'((y * sh / va) * sw + (x * sw / ha)) : 32'd0;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic check_dut(input string tag, input exp_t e, input logic [9:0] x,
                             input logic [9:0] y, input logic h, input logic v,
                             input logic b, input logic f, input logic l,
                             input logic [31:0] rom);
        chk({tag, ".DrawX"}, int'(x), int'(e.x));
        chk({tag, ".DrawY"}, int'(y), int'(e.y));
        chk({tag, ".hs"}, int'(h), int'(e.hs));
        chk({tag, ".vs"}, int'(v), int'(e.vs));
        chk({tag, ".blank"}, int'(b), int'(e.blank));
        chk({tag, ".frame_start"}, int'(f), int'(e.fs));
        chk({tag, ".line_start"}, int'(l), int'(e.ls));
        chk({tag, ".rom_address"}, int'(rom), int'(e.rom));
    endtask

    int hs_run_c = 0, vs_run_a = 0, last_fs_a = -1, last_ls_c = -1;

    task automatic compare_cycle();
        exp_t ea, eb, ec;
        ea = model(in_rst, pa, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 10, 5);
        eb = model(in_rst, pb, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, SHA, SVA);
        ec = model(in_rst, pc, 640, 16, 96, 48, 480, 10, 2, 33, 320, 240);
        check_dut("A", ea, xa, ya, hsa, vsa, bla, fsa, lsa, 32'(roma));
        check_dut("B", eb, xb, yb, hsb, vsb, blb, fsb, lsb, 32'(romb));
        check_dut("C", ec, xc, yc, hsc, vsc, blc, fsc, lsc, 32'(romc));

        // Hand-computed points that also pin the model.
        if (!in_rst) begin
            if (pa == 3 * 24 + 2) begin
                chk("A.addr(2,3)", int'(roma), 11);
                chk("model.addr(2,3)", int'(ea.rom), 11);
            end
            if (pa == 11 * 24 + 15) begin
                chk("A.addr(15,11)", int'(roma), 49);
                chk("model.addr(15,11)", int'(ea.rom), 49);
            end
            if (pa == 3 * 24 + 16) begin
                chk("A.addr(16,3)", int'(roma), 0);
                chk("A.blank(16,3)", int'(bla), 0);
            end
            if (pb == 11 * 24 + 15)
                chk("B.addr(15,11)", int'(romb), 191);
            if (pc == 2)
                chk("C.addr(2,0)", int'(romc), 1);
            if (pc == 2 * 800 + 2) begin
                chk("C.addr(2,2)", int'(romc), 321);
                chk("model.addr(2,2)", int'(ec.rom), 321);
            end
        end

        // Pulse widths and periods.
        if (in_rst) begin
            hs_run_c = 0; vs_run_a = 0; last_fs_a = -1; last_ls_c = -1;
        end else begin
            if (!hsc) hs_run_c++;
            else if (hs_run_c > 0) begin
                chk("C.hs_low_width", hs_run_c, 96);
                hs_run_c = 0;
            end
            if (!vsa) vs_run_a++;
            else if (vs_run_a > 0) begin
                chk("A.vs_low_width", vs_run_a, 48);
                vs_run_a = 0;
            end
            if (fsa) begin
                if (last_fs_a >= 0) chk("A.frame_period", cyc - last_fs_a, FA);
                last_fs_a = cyc;
            end
            if (lsc) begin
                if (last_ls_c >= 0) chk("C.line_period", cyc - last_ls_c, 800);
                last_ls_c = cyc;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (started) compare_cycle();
        end
    end

    initial begin
        bit found;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset released, running raster");
        repeat (2500) @(negedge clk);

        found = 1'b0;
        for (int i = 0; i < 2 * FA && !found; i++) begin
            @(negedge clk);
            if (pa == 5 * 24 + 7 && !in_rst) found = 1'b1;
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL mid_reset_point: position not reached, required A at (7,5)");
        end else begin
            $display("[TB] mid-frame reset at A=(7,5), held 3 cycles");
            rst = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
        end
        repeat (FA + 50) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
